fetch_unit: RTL and testbench

- Instruction-fetch stage; the consuming end of the execute stage's PC-redirect interface.
- Owns the architectural PC and issues one-outstanding requests to a variable-latency instruction memory.
- Delivers instruction plus PC+2 to decode through a stall-aware output register.
- Accepts taken-branch/jump redirects from execute, squashing wrong-path fetches, and stops on decoded HALT.

---
 rtl/fetch_unit.sv | 186 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding requests to a
// variable-latency instruction memory and hands instructions to decode.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [15:0] redirectPC,
  input  logic        halt,
  input  logic        stall,
  output logic        imemReq,
  output logic [15:0] imemAddr,
  input  logic        imemRdy,
  input  logic        imemDone,
  input  logic [15:0] imemData,
  output logic [15:0] instr,
  output logic [15:0] incPC,
  output logic        instrValid,
  output logic        halted
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic        squash_q, squash_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] inc_pc_q, inc_pc_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [15:0] buf_instr_q, buf_instr_d;
  logic [15:0] buf_pc_q, buf_pc_d;
  logic        req;
  logic        consumed;
  logic        slot_free;
  logic        halt_taken;
  logic        redirect_live;

  assign consumed      = valid_q && !stall;
  assign slot_free     = !valid_q || consumed;
  assign halt_taken    = halt && valid_q && !stall && !redirect;
  assign redirect_live = redirect && (state_q != ST_IDLE) && (state_q != ST_HALTED);

  // Next-state, datapath and memory-request logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_pc_d  = fetch_pc_q;
    squash_d    = squash_q;
    instr_d     = instr_q;
    inc_pc_d    = inc_pc_q;
    valid_d     = valid_q;
    halted_d    = halted_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    req         = 1'b0;

    if (consumed) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        req = !redirect && !halt_taken;
        if (req && imemRdy) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + 16'd2;
          state_d    = ST_WAIT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (!imemDone) begin
          state_d = ST_WAIT;
        end else if (squash_q) begin
          squash_d = 1'b0;
          state_d  = ST_FETCH;
        end else if (slot_free) begin
          instr_d  = imemData;
          inc_pc_d = fetch_pc_q + 16'd2;
          valid_d  = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          buf_instr_d = imemData;
          buf_pc_d    = fetch_pc_q;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (slot_free) begin
          instr_d  = buf_instr_q;
          inc_pc_d = buf_pc_q + 16'd2;
          valid_d  = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HALTED: begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
        state_d  = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    // A redirect outranks halt and stall; any in-flight fetch is wrong-path.
    if (redirect_live) begin
      pc_d    = redirectPC;
      valid_d = 1'b0;
      if (state_q == ST_WAIT && !imemDone) begin
        squash_d = 1'b1;
        state_d  = ST_WAIT;
      end else begin
        squash_d = 1'b0;
        state_d  = ST_FETCH;
      end
    end else if (halt_taken) begin
      valid_d  = 1'b0;
      halted_d = 1'b1;
      squash_d = 1'b0;
      state_d  = ST_HALTED;
    end else begin
      halted_d = halted_d;
    end

    if (!valid_d) begin
      instr_d = NOP_INSTR;
    end else begin
      instr_d = instr_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      fetch_pc_q  <= 16'h0000;
      squash_q    <= 1'b0;
      instr_q     <= NOP_INSTR;
      inc_pc_q    <= 16'h0000;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
      buf_instr_q <= 16'h0000;
      buf_pc_q    <= 16'h0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_pc_q  <= fetch_pc_d;
      squash_q    <= squash_d;
      instr_q     <= instr_d;
      inc_pc_q    <= inc_pc_d;
      valid_q     <= valid_d;
      halted_q    <= halted_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  assign imemReq    = req;
  assign imemAddr   = pc_q;
  assign instr      = instr_q;
  assign incPC      = inc_pc_q;
  assign instrValid = valid_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [15:0] redirectPC;
  logic        halt;
  logic        stall;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemRdy;
  logic        imemDone;
  logic [15:0] imemData;
  logic [15:0] instr;
  logic [15:0] incPC;
  logic        instrValid;
  logic        halted;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirectPC(redirectPC),
    .halt(halt), .stall(stall), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemRdy(imemRdy), .imemDone(imemDone), .imemData(imemData),
    .instr(instr), .incPC(incPC), .instrValid(instrValid), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; redirectPC = 16'h0000; halt = 1'b0;
    stall = 1'b0; imemRdy = 1'b1; imemDone = 1'b0; imemData = 16'h0000;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    settle();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (instr !== 16'h0800) begin n_err++; $display("FAIL reset_instr got %h want 0800", instr); end
    n_vec++; if (incPC !== 16'h0000) begin n_err++; $display("FAIL reset_incpc got %h want 0000", incPC); end
    n_vec++; if (instrValid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", instrValid); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", halted); end
    n_vec++; if (imemReq !== 1'b0) begin n_err++; $display("FAIL reset_idle_req got %b want 0", imemReq); end
  endtask

  task automatic test_basic_fetch();
    tick();
    n_vec++; if ({imemReq, imemAddr} !== {1'b1, 16'h0000}) begin n_err++; $display("FAIL first_req got %b/%h want 1/0000", imemReq, imemAddr); end
    tick();
    n_vec++; if (imemReq !== 1'b0) begin n_err++; $display("FAIL wait_no_req got %b want 0", imemReq); end
    imemDone = 1'b1; imemData = 16'h1111;
    tick();
    imemDone = 1'b0; settle();
    n_vec++; if ({instrValid, instr, incPC} !== {1'b1, 16'h1111, 16'h0002}) begin n_err++; $display("FAIL slot0 got %b/%h/%h want 1/1111/0002", instrValid, instr, incPC); end
    n_vec++; if ({imemReq, imemAddr} !== {1'b1, 16'h0002}) begin n_err++; $display("FAIL second_req got %b/%h want 1/0002", imemReq, imemAddr); end
    tick();
    imemDone = 1'b1; imemData = 16'h2222;
    tick();
    imemDone = 1'b0; settle();
    n_vec++; if ({instrValid, instr, incPC} !== {1'b1, 16'h2222, 16'h0004}) begin n_err++; $display("FAIL slot1 got %b/%h/%h want 1/2222/0004", instrValid, instr, incPC); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL basic_halted got %b want 0", halted); end
  endtask

  task automatic test_stall_skid();
    tick();
    imemDone = 1'b1; imemData = 16'h3333;
    tick();
    imemDone = 1'b0; stall = 1'b1; settle();
    n_vec++; if ({instrValid, instr, incPC} !== {1'b1, 16'h3333, 16'h0006}) begin n_err++; $display("FAIL slot3333 got %b/%h/%h want 1/3333/0006", instrValid, instr, incPC); end
    n_vec++; if ({imemReq, imemAddr} !== {1'b1, 16'h0006}) begin n_err++; $display("FAIL stall_req got %b/%h want 1/0006", imemReq, imemAddr); end
    tick();
    imemDone = 1'b1; imemData = 16'h4444;
    tick();
    imemDone = 1'b0; settle();
    for (int i = 0; i < 2; i++) begin
      n_vec++; if ({instrValid, instr, incPC} !== {1'b1, 16'h3333, 16'h0006}) begin n_err++; $display("FAIL hold_slot%0d got %b/%h/%h want 1/3333/0006", i, instrValid, instr, incPC); end
      n_vec++; if (imemReq !== 1'b0) begin n_err++; $display("FAIL hold_req%0d got %b want 0", i, imemReq); end
      if (i == 0) tick();
    end
    stall = 1'b0;
    tick();
    n_vec++; if ({instrValid, instr, incPC} !== {1'b1, 16'h4444, 16'h0008}) begin n_err++; $display("FAIL skid_out got %b/%h/%h want 1/4444/0008", instrValid, instr, incPC); end
    n_vec++; if ({imemReq, imemAddr} !== {1'b1, 16'h0008}) begin n_err++; $display("FAIL after_skid_req got %b/%h want 1/0008", imemReq, imemAddr); end
  endtask

  task automatic test_redirect_wait();
    tick();
    redirect = 1'b1; redirectPC = 16'h0040;
    tick();
    redirect = 1'b0; settle();
    n_vec++; if ({instrValid, imemReq} !== 2'b00) begin n_err++; $display("FAIL squash_wait got %b%b want 00", instrValid, imemReq); end
    tick();
    imemDone = 1'b1; imemData = 16'hDEAD;
    tick();
    imemDone = 1'b0; settle();
    n_vec++; if ({instrValid, instr} !== {1'b0, 16'h0800}) begin n_err++; $display("FAIL squashed_data got %b/%h want 0/0800", instrValid, instr); end
    n_vec++; if ({imemReq, imemAddr} !== {1'b1, 16'h0040}) begin n_err++; $display("FAIL redirect_req got %b/%h want 1/0040", imemReq, imemAddr); end
    tick();
    n_vec++; if (instrValid !== 1'b0) begin n_err++; $display("FAIL redirect_wait_valid got %b want 0", instrValid); end
    imemDone = 1'b1; imemData = 16'h5555;
    tick();
    imemDone = 1'b0; settle();
    n_vec++; if ({instrValid, instr, incPC} !== {1'b1, 16'h5555, 16'h0042}) begin n_err++; $display("FAIL redirect_slot got %b/%h/%h want 1/5555/0042", instrValid, instr, incPC); end
  endtask

  task automatic test_redirect_done();
    tick();
    redirect = 1'b1; redirectPC = 16'h0080; imemDone = 1'b1; imemData = 16'hBEEF;
    tick();
    redirect = 1'b0; imemDone = 1'b0; settle();
    n_vec++; if ({instrValid, instr} !== {1'b0, 16'h0800}) begin n_err++; $display("FAIL rd_done_discard got %b/%h want 0/0800", instrValid, instr); end
    n_vec++; if ({imemReq, imemAddr} !== {1'b1, 16'h0080}) begin n_err++; $display("FAIL rd_done_req got %b/%h want 1/0080", imemReq, imemAddr); end
    tick();
    imemDone = 1'b1; imemData = 16'h6666;
    tick();
    imemDone = 1'b0; settle();
    n_vec++; if ({instrValid, instr, incPC} !== {1'b1, 16'h6666, 16'h0082}) begin n_err++; $display("FAIL rd_done_slot got %b/%h/%h want 1/6666/0082", instrValid, instr, incPC); end
  endtask

  task automatic test_halt();
    stall = 1'b1;
    tick();
    stall = 1'b0; halt = 1'b1; settle();
    n_vec++; if (imemReq !== 1'b0) begin n_err++; $display("FAIL halt_wait_req got %b want 0", imemReq); end
    tick();
    halt = 1'b0; settle();
    n_vec++; if ({halted, instrValid, imemReq} !== 3'b100) begin n_err++; $display("FAIL halt_enter got %b%b%b want 100", halted, instrValid, imemReq); end
    imemDone = 1'b1; imemData = 16'h7777;
    tick();
    imemDone = 1'b0; settle();
    n_vec++; if ({halted, instrValid, imemReq, instr} !== {3'b100, 16'h0800}) begin n_err++; $display("FAIL halt_late_done got %b%b%b/%h want 100/0800", halted, instrValid, imemReq, instr); end
    tick();
    n_vec++; if ({halted, imemReq} !== 2'b10) begin n_err++; $display("FAIL halt_sticky got %b%b want 10", halted, imemReq); end
    do_reset();
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_cleared got %b want 0", halted); end
    tick(); tick();
    imemDone = 1'b1; imemData = 16'h1234;
    tick();
    imemDone = 1'b0; halt = 1'b1; redirect = 1'b1; redirectPC = 16'h0100; settle();
    n_vec++; if ({instrValid, imemReq} !== 2'b10) begin n_err++; $display("FAIL hr_pre got %b%b want 10", instrValid, imemReq); end
    tick();
    halt = 1'b0; redirect = 1'b0; settle();
    n_vec++; if ({halted, instrValid} !== 2'b00) begin n_err++; $display("FAIL hr_not_halted got %b%b want 00", halted, instrValid); end
    n_vec++; if ({imemReq, imemAddr} !== {1'b1, 16'h0100}) begin n_err++; $display("FAIL hr_req got %b/%h want 1/0100", imemReq, imemAddr); end
  endtask

  task automatic test_wrap_and_reset();
    redirect = 1'b1; redirectPC = 16'hFFFE;
    tick();
    redirect = 1'b0; settle();
    n_vec++; if ({imemReq, imemAddr} !== {1'b1, 16'hFFFE}) begin n_err++; $display("FAIL wrap_req got %b/%h want 1/fffe", imemReq, imemAddr); end
    tick();
    imemDone = 1'b1; imemData = 16'h9999;
    tick();
    imemDone = 1'b0; settle();
    n_vec++; if ({instrValid, instr, incPC} !== {1'b1, 16'h9999, 16'h0000}) begin n_err++; $display("FAIL wrap_slot got %b/%h/%h want 1/9999/0000", instrValid, instr, incPC); end
    n_vec++; if ({imemReq, imemAddr} !== {1'b1, 16'h0000}) begin n_err++; $display("FAIL wrap_next got %b/%h want 1/0000", imemReq, imemAddr); end
    tick();
    redirect = 1'b1; redirectPC = 16'h0200;
    tick();
    redirect = 1'b0;
    rst_n = 1'b0;
    settle();
    n_vec++; if ({instr, incPC, instrValid, halted, imemReq} !== {16'h0800, 16'h0000, 3'b000}) begin n_err++; $display("FAIL mid_reset got %h/%h/%b%b%b want 0800/0000/000", instr, incPC, instrValid, halted, imemReq); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_vec++; if ({imemReq, imemAddr} !== {1'b1, 16'h0000}) begin n_err++; $display("FAIL post_reset_req got %b/%h want 1/0000", imemReq, imemAddr); end
    tick();
    imemDone = 1'b1; imemData = 16'hAAAA;
    tick();
    imemDone = 1'b0; settle();
    n_vec++; if ({instrValid, instr, incPC} !== {1'b1, 16'hAAAA, 16'h0002}) begin n_err++; $display("FAIL squash_cleared got %b/%h/%h want 1/aaaa/0002", instrValid, instr, incPC); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall_skid();
    test_redirect_wait();
    test_redirect_done();
    test_halt();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
